unidad_emision: RTL and testbench

// - Fetch/issue stage feeding the vector control decoder: reads instruction memory, buffers words, presents opcode + instruction with valid/ready.
// - Produces the 5-bit opcode stream (LOAD 00000, STORE 00001, RESTA 00010, SUMA 00011, XOR 00100, shifts 00110-01010) the decoder consumes.
// - Handles decoder back-pressure, redirect (jump) flush and HALT opcode drain.

---
 rtl/unidad_emision.sv | 194 +++++++++++++++++++
 tb/tb_unidad_emision.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidad_emision.sv
// -----------------------------------------------------------------------------
// unidad_emision
// Fetch/issue stage that feeds the vector control decoder. It reads the
// instruction memory one word at a time, buffers the returned words in a small
// prefetch FIFO and presents the head entry to the decoder with a
// valid/ready handshake. The stage also handles decoder back-pressure,
// redirect (jump) flushes and the HALT opcode, which stops fetching and lets
// the buffered instructions drain.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous, active-high reset
//   start        : begin fetching from PC_RST (only honoured in IDLE/HALT)
//   imem_rd      : instruction memory read strobe (data returns 1 cycle later)
//   imem_addr    : word address of the read, 0 when no read is issued
//   imem_data    : read data, valid the cycle after imem_rd
//   instr_valid  : FIFO head is valid
//   instr_ready  : decoder accepts the head (transfer = valid & ready)
//   instr_out    : FIFO head instruction
//   opcode_out   : opcode field of instr_out
//   pc_out       : address of the FIFO head instruction
//   redirect     : flush the pipeline and jump
//   redirect_pc  : jump target
//   halted       : high exactly while in the HALT state
// -----------------------------------------------------------------------------
module unidad_emision #(
    parameter int                ADDR_W  = 10,
    parameter int                INSTR_W = 32,
    parameter int                DEPTH   = 2,
    parameter logic [4:0]        HALT_OP = 5'b11111,
    parameter logic [ADDR_W-1:0] PC_RST  = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               imem_rd,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [4:0]         opcode_out,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_HALT
    } state_t;

    state_t state;

    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] fifo_instr [DEPTH];
    logic [ADDR_W-1:0]  fifo_pc    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               inflight;
    logic [ADDR_W-1:0]  inflight_addr;

    logic               running;
    logic               resp_halt;
    logic               push;
    logic               pop;
    logic               issue;
    logic               flush;
    logic [CNT_W:0]     occupancy;

    assign running = (state == ST_FETCH) || (state == ST_DRAIN);

    // The FIFO is always empty in IDLE/HALT, the state gate only makes that
    // explicit on the handshake.
    assign instr_valid = running && (count != '0);
    assign pop         = instr_valid && instr_ready;

    // A returning word carrying HALT_OP ends the fetch stream and is never
    // buffered. A redirect drops whatever response is arriving.
    assign resp_halt = inflight && (imem_data[INSTR_W-1 -: 5] == HALT_OP);
    assign flush     = redirect && running;
    assign push      = inflight && !resp_halt && !redirect;

    // Credit check: entries left after this edge plus the word still coming
    // back must leave room for a new read, so the FIFO can never overflow.
    assign occupancy = {1'b0, count}
                     - {{CNT_W{1'b0}}, pop}
                     + {{CNT_W{1'b0}}, inflight};

    // Reads are suppressed while the HALT word is returning so that nothing
    // past the HALT address is ever requested, and during a redirect so the
    // first read after the jump is the target itself.
    assign issue = !rst && (state == ST_FETCH) && !redirect && !resp_halt
                && (occupancy < DEPTH_C);

    assign imem_rd   = issue;
    assign imem_addr = issue ? pc : '0;

    // Head outputs are forced to zero while nothing is valid, so reset and
    // flush leave clean zeros on the decoder side.
    assign instr_out  = instr_valid ? fifo_instr[rd_ptr] : '0;
    assign pc_out     = instr_valid ? fifo_pc[rd_ptr]    : '0;
    assign opcode_out = instr_out[INSTR_W-1 -: 5];

    // FIFO storage carries no reset; only the pointers and count matter.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_instr[wr_ptr] <= imem_data;
            fifo_pc[wr_ptr]    <= inflight_addr;
        end
    end

    // Control FSM together with the PC, the in-flight tracker and the FIFO
    // bookkeeping. A redirect in FETCH/DRAIN outranks every other event
    // except reset; a transfer in the same cycle is simply treated as taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            pc            <= PC_RST;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            halted        <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_addr <= pc;
                pc            <= pc + ADDR_W'(1);
            end

            if (flush) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                inflight <= 1'b0;
                pc       <= redirect_pc;
                state    <= ST_FETCH;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (!push && pop) begin
                    count <= count - CNT_W'(1);
                end

                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state <= ST_FETCH;
                            pc    <= PC_RST;
                        end
                    end
                    ST_FETCH: begin
                        if (resp_halt) begin
                            state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (count == '0) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end
                    end
                    ST_HALT: begin
                        if (start) begin
                            state  <= ST_FETCH;
                            pc     <= PC_RST;
                            halted <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_unidad_emision.sv
// -----------------------------------------------------------------------------
// tb_unidad_emision
// Self-checking bench for unidad_emision. The reference model treats the
// stage as a program-order stream: instructions must reach the decoder in
// address order from the start/jump point, reads must walk the same order
// and stop at a HALT word, and a stalled head must not change.
// -----------------------------------------------------------------------------
module tb_unidad_emision;

    localparam int         ADDR_W  = 10;
    localparam int         INSTR_W = 32;
    localparam int         DEPTH   = 2;
    localparam logic [4:0] HALT_OP = 5'b11111;
    localparam logic [9:0] PC_RST  = 10'd0;

    logic               clk;
    logic               rst;
    logic               start;
    logic               imem_rd;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_out;
    logic [4:0]         opcode_out;
    logic [ADDR_W-1:0]  pc_out;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halted;

    logic [31:0] mem [0:1023];
    logic [31:0] next_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int reads  = 0;
    int xfers  = 0;

    logic [9:0]  exp_pc;
    logic [9:0]  exp_fetch;
    logic [9:0]  last_read;
    logic        halt_fetched;
    logic        wrap_seen;
    logic        prev_stall;
    logic [41:0] prev_head;

    unidad_emision #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W),
        .DEPTH  (DEPTH),
        .HALT_OP(HALT_OP),
        .PC_RST (PC_RST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_rd    (imem_rd),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_out  (instr_out),
        .opcode_out (opcode_out),
        .pc_out     (pc_out),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [4:0] op);
        return {op, 27'($urandom)};
    endfunction

    // Any defined non-HALT opcode: 0..4 and the shifts 6..10.
    function automatic logic [4:0] randOp();
        int k;
        k = $urandom_range(0, 9);
        return (k < 5) ? 5'(k) : 5'(k + 1);
    endfunction

    function automatic logic randReady();
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model for one cycle; inputs and outputs here are the values
    // the DUT will see at the coming rising edge.
    task automatic observeCycle();
        logic [31:0] w;
        if (rst) begin
            prev_stall = 1'b0;
            next_data  = $urandom;
        end else begin
            if (halted) begin
                checkOutput("valid_low_in_halt", 64'(instr_valid), 64'd0);
            end
            if (instr_valid) begin
                checkOutput("halt_op_issued", 64'(opcode_out == HALT_OP), 64'd0);
            end
            if (prev_stall) begin
                checkOutput("stall_valid", 64'(instr_valid), 64'd1);
                checkOutput("stall_head", 64'({pc_out, instr_out}), 64'(prev_head));
            end
            if (instr_valid && instr_ready) begin
                w = mem[exp_pc];
                checkOutput("xfer_pc", 64'(pc_out), 64'(exp_pc));
                checkOutput("xfer_instr", 64'(instr_out), 64'(w));
                checkOutput("xfer_opcode", 64'(opcode_out), 64'(w[31:27]));
                exp_pc = exp_pc + 10'd1;
                xfers++;
            end
            if (imem_rd) begin
                checkOutput("fetch_addr", 64'(imem_addr), 64'(exp_fetch));
                checkOutput("read_after_halt", 64'(halt_fetched), 64'd0);
                w = mem[exp_fetch];
                if (w[31:27] == HALT_OP) halt_fetched = 1'b1;
                if (imem_addr == 10'h000 && last_read == 10'h3FF) wrap_seen = 1'b1;
                last_read = imem_addr;
                exp_fetch = exp_fetch + 10'd1;
                reads++;
                next_data = mem[imem_addr];
            end else begin
                next_data = $urandom;
            end
            if (redirect) begin
                exp_pc       = redirect_pc;
                exp_fetch    = redirect_pc;
                halt_fetched = 1'b0;
            end
            if (start) begin
                exp_pc       = PC_RST;
                exp_fetch    = PC_RST;
                halt_fetched = 1'b0;
            end
            prev_stall = instr_valid && !instr_ready && !redirect;
            prev_head  = {pc_out, instr_out};
        end
        cyc++;
    endtask

    task automatic applyStimulus(input logic s_rst, input logic s_start, input logic s_ready,
                                 input logic s_redirect, input logic [9:0] s_rpc);
        @(negedge clk);
        rst         = s_rst;
        start       = s_start;
        instr_ready = s_ready;
        redirect    = s_redirect;
        redirect_pc = s_rpc;
        imem_data   = next_data;
        #1;
        observeCycle();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_imem_rd"}, 64'(imem_rd), 64'd0);
        checkOutput({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
        checkOutput({tag, "_valid"}, 64'(instr_valid), 64'd0);
        checkOutput({tag, "_instr"}, 64'(instr_out), 64'd0);
        checkOutput({tag, "_opcode"}, 64'(opcode_out), 64'd0);
        checkOutput({tag, "_pc"}, 64'(pc_out), 64'd0);
        checkOutput({tag, "_halted"}, 64'(halted), 64'd0);
    endtask

    initial begin
        int  first_rd;
        int  first_v;
        logic found;

        rst = 1'b1; start = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
        redirect_pc = '0; imem_data = '0; next_data = '0;
        exp_pc = '0; exp_fetch = '0; last_read = '0;
        halt_fetched = 1'b0; wrap_seen = 1'b0; prev_stall = 1'b0; prev_head = '0;

        for (int a = 0; a < 1024; a++) mem[a] = mk(randOp());
        mem[0] = mk(5'b00011);
        mem[1] = mk(5'b00010);
        mem[2] = mk(5'b00100);
        mem[3] = mk(HALT_OP);

        $display("[TB] reset and idle");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
        checkAllZero("reset");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
        checkOutput("idle_no_read", 64'(imem_rd), 64'd0);

        $display("[TB] SUMA/RESTA/XOR/HALT program");
        reads = 0; xfers = 0; first_rd = -1; first_v = -1;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 10'd0);
        for (int i = 0; i < 40 && !halted; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
            if (imem_rd && first_rd < 0) first_rd = cyc;
            if (instr_valid && first_v < 0) first_v = cyc;
        end
        checkOutput("progA_halted", 64'(halted), 64'd1);
        checkOutput("progA_xfers", 64'(xfers), 64'd3);
        checkOutput("progA_reads", 64'(reads), 64'd4);
        checkOutput("progA_latency", 64'(first_v - first_rd), 64'd2);

        $display("[TB] restart from HALT with decoder stalled");
        for (int a = 0; a < 1024; a++) mem[a] = mk(randOp());
        mem[0]     = mk(5'b00000);
        mem[10'h40] = mk(HALT_OP);
        reads = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        checkOutput("restart_halted", 64'(halted), 64'd0);
        checkOutput("restart_rd", 64'(imem_rd), 64'd1);
        checkOutput("restart_addr", 64'(imem_addr), 64'(PC_RST));
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        checkOutput("stall_reads", 64'(reads), 64'(DEPTH));
        checkOutput("stall_no_rd", 64'(imem_rd), 64'd0);
        checkOutput("stall_valid_head", 64'(instr_valid), 64'd1);
        checkOutput("stall_opcode_load", 64'(opcode_out), 64'd0);
        checkOutput("stall_pc0", 64'(pc_out), 64'd0);

        $display("[TB] redirect while read of 0x05 in flight");
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            applyStimulus(1'b0, 1'b0, randReady(), 1'b0, 10'd0);
            if (imem_rd && imem_addr == 10'h005) found = 1'b1;
        end
        checkOutput("find_read_0x05", 64'(found), 64'd1);
        applyStimulus(1'b0, 1'b0, randReady(), 1'b1, 10'h020);
        checkOutput("redirect_cycle_no_rd", 64'(imem_rd), 64'd0);
        applyStimulus(1'b0, 1'b0, randReady(), 1'b0, 10'd0);
        checkOutput("after_redirect_valid", 64'(instr_valid), 64'd0);
        checkOutput("after_redirect_rd", 64'(imem_rd), 64'd1);
        checkOutput("after_redirect_addr", 64'(imem_addr), 64'h020);
        xfers = 0;
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0, randReady(), 1'b0, 10'd0);
        checkOutput("stream_after_redirect", 64'(xfers > 0), 64'd1);

        $display("[TB] PC wrap at top of memory");
        wrap_seen = 1'b0;
        applyStimulus(1'b0, 1'b0, randReady(), 1'b1, 10'h3FE);
        for (int i = 0; i < 40 && !wrap_seen; i++) begin
            applyStimulus(1'b0, 1'b0, randReady(), 1'b0, 10'd0);
        end
        checkOutput("pc_wrap", 64'(wrap_seen), 64'd1);

        $display("[TB] reset mid-stream");
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
            if (instr_valid) found = 1'b1;
        end
        checkOutput("midreset_head_valid", 64'(found), 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
        checkAllZero("midreset");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
            checkOutput("midreset_idle_no_rd", 64'(imem_rd), 64'd0);
        end

        $display("[TB] run to HALT at 0x40 then restart");
        reads = 0;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 10'd0);
        for (int i = 0; i < 200 && !halted; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
        end
        checkOutput("progB_halted", 64'(halted), 64'd1);
        checkOutput("progB_reads", 64'(reads), 64'd65);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 10'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
        checkOutput("halt_restart_halted", 64'(halted), 64'd0);
        checkOutput("halt_restart_rd", 64'(imem_rd), 64'd1);
        checkOutput("halt_restart_addr", 64'(imem_addr), 64'(PC_RST));
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
